// File: rtl/sdram_refresh_scheduler.sv
// Periodic SDRAM refresh scheduler: post-reset init burst, tREFI tick generation,
// bounded refresh debt with urgency, and retention-window refresh counting.
module sdram_refresh_scheduler #(
    parameter int unsigned REFI_CYCLES     = 780,
    parameter int unsigned INIT_REFRESHES  = 8,
    parameter int unsigned MAX_DEBT        = 8,
    parameter int unsigned URGENT_LVL      = 6,
    parameter int unsigned REFS_PER_WINDOW = 8192,
    localparam int unsigned DEBT_W  = $clog2(MAX_DEBT + 1),
    localparam int unsigned CNT_W   = $clog2(REFS_PER_WINDOW)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              ref_ack,
    output logic              ref_req,
    output logic              ref_urgent,
    output logic [DEBT_W-1:0] ref_debt,
    output logic              init_done,
    output logic [CNT_W-1:0]  ref_count,
    output logic              window_done,
    output logic              overflow
);

    localparam int unsigned TIMER_W = $clog2(REFI_CYCLES);
    localparam int unsigned INIT_W  = $clog2(INIT_REFRESHES + 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [INIT_W-1:0]   init_left_q, init_left_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [DEBT_W-1:0]   debt_d;
    logic [CNT_W-1:0]    count_d;
    logic                init_done_d;
    logic                window_done_d;
    logic                overflow_d;
    logic                ref_req_d;
    logic                ref_urgent_d;
    logic                tick;
    logic                ack_ok;

    // State and output registers; outputs are precomputed for the next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_left_q <= INIT_W'(INIT_REFRESHES);
            timer_q     <= '0;
            ref_debt    <= '0;
            ref_count   <= '0;
            init_done   <= 1'b0;
            window_done <= 1'b0;
            overflow    <= 1'b0;
            ref_req     <= 1'b1;
            ref_urgent  <= 1'b1;
        end else begin
            state_q     <= state_d;
            init_left_q <= init_left_d;
            timer_q     <= timer_d;
            ref_debt    <= debt_d;
            ref_count   <= count_d;
            init_done   <= init_done_d;
            window_done <= window_done_d;
            overflow    <= overflow_d;
            ref_req     <= ref_req_d;
            ref_urgent  <= ref_urgent_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        init_left_d   = init_left_q;
        timer_d       = timer_q;
        debt_d        = ref_debt;
        count_d       = ref_count;
        init_done_d   = init_done;
        window_done_d = 1'b0;
        overflow_d    = overflow;
        tick          = 1'b0;
        ack_ok        = 1'b0;

        case (state_q)
            ST_INIT: begin
                timer_d = '0;
                if (ref_ack) begin
                    if (init_left_q == INIT_W'(1)) begin
                        state_d     = ST_RUN;
                        init_done_d = 1'b1;
                    end
                    init_left_d = init_left_q - INIT_W'(1);
                end
            end
            ST_RUN: begin
                tick   = en && (timer_q == TIMER_W'(REFI_CYCLES - 1));
                ack_ok = ref_ack && (ref_debt != '0);
                if (en) begin
                    timer_d = tick ? '0 : timer_q + TIMER_W'(1);
                end
                // A tick cancels against an accepted ack on the same edge
                if (tick && !ack_ok) begin
                    if (ref_debt == DEBT_W'(MAX_DEBT)) begin
                        overflow_d = 1'b1;
                    end else begin
                        debt_d = ref_debt + DEBT_W'(1);
                    end
                end else if (ack_ok && !tick) begin
                    debt_d = ref_debt - DEBT_W'(1);
                end
                if (ack_ok) begin
                    if (ref_count == CNT_W'(REFS_PER_WINDOW - 1)) begin
                        count_d       = '0;
                        window_done_d = 1'b1;
                    end else begin
                        count_d = ref_count + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase

        ref_req_d    = (state_d == ST_INIT) || (debt_d != '0);
        ref_urgent_d = (state_d == ST_INIT) || (debt_d >= DEBT_W'(URGENT_LVL));
    end

endmodule

// File: tb/tb_sdram_refresh_scheduler.sv
// Bench for sdram_refresh_scheduler: directed vector table, async-reset corner,
// and randomized traffic checked against an arithmetic reference model.
module tb_sdram_refresh_scheduler;

    localparam int REFI  = 10;
    localparam int INITN = 2;
    localparam int MAXD  = 4;
    localparam int URG   = 3;
    localparam int WIN   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       ref_ack = 1'b0;
    logic       ref_req, ref_urgent, init_done, window_done, overflow;
    logic [2:0] ref_debt;
    logic [1:0] ref_count;

    int checks = 0;
    int failures = 0;

    sdram_refresh_scheduler #(
        .REFI_CYCLES(REFI), .INIT_REFRESHES(INITN), .MAX_DEBT(MAXD),
        .URGENT_LVL(URG), .REFS_PER_WINDOW(WIN)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .ref_ack(ref_ack),
        .ref_req(ref_req), .ref_urgent(ref_urgent), .ref_debt(ref_debt),
        .init_done(init_done), .ref_count(ref_count),
        .window_done(window_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model: counts acks and enabled edges, derives everything arithmetically
    bit m_in_init;
    int m_acks;
    int m_en_edges;
    int m_debt;
    int m_cnt;
    bit m_wd;
    bit m_ovf;

    task automatic model_reset();
        m_in_init  = 1'b1;
        m_acks     = 0;
        m_en_edges = 0;
        m_debt     = 0;
        m_cnt      = 0;
        m_wd       = 1'b0;
        m_ovf      = 1'b0;
    endtask

    task automatic model_edge(input bit r, input bit e, input bit a);
        bit tick;
        bit accepted;
        if (r) begin
            model_reset();
            return;
        end
        m_wd = 1'b0;
        if (m_in_init) begin
            if (a) m_acks++;
            if (m_acks == INITN) begin
                m_in_init  = 1'b0;
                m_en_edges = 0;
            end
            return;
        end
        tick = e && (((m_en_edges + 1) % REFI) == 0);
        if (e) m_en_edges++;
        accepted = a && (m_debt > 0);
        if (accepted) begin
            m_cnt = (m_cnt + 1) % WIN;
            m_wd  = (m_cnt == 0);
        end
        if (tick && !accepted) begin
            if (m_debt == MAXD) m_ovf = 1'b1;
            else m_debt++;
        end else if (accepted && !tick) begin
            m_debt--;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int req, input int urg, input int debt,
                           input int idone, input int cnt, input int wd, input int ovf);
        chk({tag, ".ref_req"},     int'(ref_req),     req);
        chk({tag, ".ref_urgent"},  int'(ref_urgent),  urg);
        chk({tag, ".ref_debt"},    int'(ref_debt),    debt);
        chk({tag, ".init_done"},   int'(init_done),   idone);
        chk({tag, ".ref_count"},   int'(ref_count),   cnt);
        chk({tag, ".window_done"}, int'(window_done), wd);
        chk({tag, ".overflow"},    int'(overflow),    ovf);
    endtask

    task automatic chk_model(input string tag);
        chk_all(tag, int'(m_in_init || m_debt != 0), int'(m_in_init || m_debt >= URG),
                m_debt, int'(!m_in_init), m_cnt, int'(m_wd), int'(m_ovf));
    endtask

    // One clock: drive at negedge, model on posedge, sample 1 time unit later
    task automatic step(input bit r, input bit e, input bit a, input bit do_model_chk);
        @(negedge clk);
        rst = r; en = e; ref_ack = a;
        @(posedge clk);
        model_edge(r, e, a);
        #1;
        if (do_model_chk) chk_model("model");
    endtask

    typedef struct {
        bit r, e, a;
        int n;
        bit req, urg;
        int debt;
        bit idone;
        int cnt;
        bit wd, ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit r, input bit e, input bit a, input int n,
                                input bit req, input bit urg, input int debt, input bit idone,
                                input int cnt, input bit wd, input bit ovf);
        vec_t v;
        v.r = r; v.e = e; v.a = a; v.n = n;
        v.req = req; v.urg = urg; v.debt = debt; v.idone = idone;
        v.cnt = cnt; v.wd = wd; v.ovf = ovf;
        tbl.push_back(v);
    endfunction

    initial begin
        model_reset();
        //    r  e  a   n   req urg debt id cnt wd ovf
        add(1, 0, 0,  2,  1,  1,  0,  0, 0, 0, 0);  // reset values
        add(0, 1, 1,  1,  1,  1,  0,  0, 0, 0, 0);  // first init ack
        add(0, 1, 1,  1,  0,  0,  0,  1, 0, 0, 0);  // init exit
        add(0, 1, 0,  9,  0,  0,  0,  1, 0, 0, 0);  // just before first tick
        add(0, 1, 0,  1,  1,  0,  1,  1, 0, 0, 0);  // first tick
        add(0, 1, 0, 10,  1,  0,  2,  1, 0, 0, 0);
        add(0, 1, 0, 10,  1,  1,  3,  1, 0, 0, 0);  // urgent at 3
        add(0, 1, 0, 10,  1,  1,  4,  1, 0, 0, 0);
        add(0, 1, 0, 10,  1,  1,  4,  1, 0, 0, 1);  // saturated tick
        add(0, 0, 1,  1,  1,  1,  3,  1, 1, 0, 1);
        add(0, 0, 1,  1,  1,  0,  2,  1, 2, 0, 1);
        add(0, 1, 0,  9,  1,  0,  2,  1, 2, 0, 1);
        add(0, 1, 1,  1,  1,  0,  2,  1, 3, 0, 1);  // ack on tick edge
        add(0, 0, 1,  1,  1,  0,  1,  1, 0, 1, 1);  // window wrap
        add(0, 0, 0,  1,  1,  0,  1,  1, 0, 0, 1);  // window_done one cycle only
        add(0, 0, 1,  1,  0,  0,  0,  1, 1, 0, 1);
        add(0, 0, 1,  1,  0,  0,  0,  1, 1, 0, 1);  // ack with zero debt ignored
        add(0, 1, 0,  5,  0,  0,  0,  1, 1, 0, 1);  // timer at 5
        add(0, 0, 0, 25,  0,  0,  0,  1, 1, 0, 1);  // frozen
        add(0, 1, 0,  4,  0,  0,  0,  1, 1, 0, 1);
        add(0, 1, 0,  1,  1,  0,  1,  1, 1, 0, 1);  // tick 5 enabled cycles later
        add(0, 1, 0, 20,  1,  1,  3,  1, 1, 0, 1);
        add(1, 0, 0,  1,  1,  1,  0,  0, 0, 0, 0);  // reset in RUN with debt
        add(0, 1, 1,  1,  1,  1,  0,  0, 0, 0, 0);
        add(1, 0, 0,  1,  1,  1,  0,  0, 0, 0, 0);  // reset mid-INIT
        add(0, 0, 1,  1,  1,  1,  0,  0, 0, 0, 0);
        add(0, 0, 1,  1,  0,  0,  0,  1, 0, 0, 0);  // two fresh acks needed

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].r, tbl[i].e, tbl[i].a, 1'b0);
            chk_all($sformatf("vec%0d", i), int'(tbl[i].req), int'(tbl[i].urg), tbl[i].debt,
                    int'(tbl[i].idone), tbl[i].cnt, int'(tbl[i].wd), int'(tbl[i].ovf));
            chk_model($sformatf("vec%0d.model", i));
        end

        // Asynchronous reset between edges with debt and count pending
        for (int k = 0; k < 25; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b1; en = 1'b0; ref_ack = 1'b0;
        model_reset();
        #1;
        chk_all("async_rst", 1, 1, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b1);

        // Randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            step(($urandom_range(0, 599) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 5) == 0), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
